// File: rtl/fsm_counter_pkg.sv
// Shared types and constants for the key-driven N-bit FSM counter.
package fsm_counter_pkg;

  // Press/release handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Decoded operation applied on one press.
  typedef enum logic [2:0] {
    OP_SEED = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4
  } op_e;

  // Value loaded by a check (seed) operation.
  localparam logic [15:0] DEFAULT_SEED = 16'h1382;

endpackage

// File: rtl/fsm_counter_alu.sv
// Combinational datapath: add/sub with wrap or clamp, and shift/rotate by one.
// The seed load is handled by the caller; for OP_SEED the count passes through.
module fsm_counter_alu
  import fsm_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STEP_W   = 4,
  parameter bit          SATURATE = 1'b0,
  parameter bit          ROTATE   = 1'b0
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] count,
  input  logic [STEP_W-1:0] value,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf
);

  // Arithmetic is done one bit wider so the top bit is the carry or borrow.
  logic [WIDTH:0] val_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign val_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, value};
  assign sum     = {1'b0, count} + val_ext;
  assign diff    = {1'b0, count} - val_ext;

  // Select the result for the requested operation.
  always_comb begin
    next_count = count;
    ovf        = 1'b0;
    case (op)
      OP_ADD: begin
        ovf = sum[WIDTH];
        if (SATURATE && sum[WIDTH]) next_count = '1;
        else                        next_count = sum[WIDTH-1:0];
      end
      OP_SUB: begin
        ovf = diff[WIDTH];
        if (SATURATE && diff[WIDTH]) next_count = '0;
        else                         next_count = diff[WIDTH-1:0];
      end
      OP_SHL: begin
        if (ROTATE) next_count = {count[WIDTH-2:0], count[WIDTH-1]};
        else        next_count = {count[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        if (ROTATE) next_count = {count[0], count[WIDTH-1:1]};
        else        next_count = {1'b0, count[WIDTH-1:1]};
      end
      default: begin
        next_count = count;
        ovf        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fsm_counter_nbit.sv
// Key-driven N-bit counter: one operation per press of enable.
//
// Handshake: enable is a level. Seen high in IDLE it moves to EXEC; the op is
// applied on the EXEC edge (operands sampled there) and op_done pulses for the
// cycle in which the new count is visible. HOLD waits for enable to drop, so a
// held key yields exactly one op. Reset lands in HOLD so a key held through
// reset must be released first.
module fsm_counter_nbit
  import fsm_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      STEP_W   = 4,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
  parameter bit               SATURATE = 1'b0,
  parameter bit               ROTATE   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              check,
  input  logic              mode,
  input  logic              direction,
  input  logic [STEP_W-1:0] value,
  output logic [WIDTH-1:0]  count,
  output logic              overflow,
  output logic              zero,
  output logic              op_done,
  output state_e            dbg_state_o
);

  state_e           state_q, state_d;
  logic             exec;
  op_e              op;
  logic [WIDTH-1:0] alu_next;
  logic             alu_ovf;

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             op_done_q, op_done_d;

  // State register; reset parks in HOLD.
  always_ff @(posedge clock) begin
    if (reset) state_q <= HOLD;
    else       state_q <= state_d;
  end

  // Next-state logic for the press/release handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (!enable) state_d = IDLE;
      default: state_d = HOLD;
    endcase
  end

  // FSM output: the op is applied on the edge that leaves EXEC.
  always_comb begin
    exec = (state_q == EXEC);
  end

  // Op decode; check overrides mode and direction.
  always_comb begin
    if (check)     op = OP_SEED;
    else if (mode) op = direction ? OP_SUB : OP_ADD;
    else           op = direction ? OP_SHR : OP_SHL;
  end

  fsm_counter_alu #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .SATURATE (SATURATE),
    .ROTATE   (ROTATE)
  ) u_alu (
    .op         (op),
    .count      (count_q),
    .value      (value),
    .next_count (alu_next),
    .ovf        (alu_ovf)
  );

  // Datapath next values; overflow is sticky until a seed load.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    op_done_d  = exec;
    if (exec) begin
      if (op == OP_SEED) begin
        count_d    = SEED;
        overflow_d = 1'b0;
      end else begin
        count_d    = alu_next;
        overflow_d = overflow_q | alu_ovf;
      end
    end
    zero_d = (count_d == '0);
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      op_done_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      op_done_q  <= op_done_d;
    end
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;
  assign op_done     = op_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fsm_counter_nbit.sv
// Bench for fsm_counter_nbit: three instances (wrap/shift, saturate, rotate)
// share one stimulus stream and are compared against an arithmetic model.
module tb_fsm_counter_nbit;
  import fsm_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       check;
  logic       mode;
  logic       direction;
  logic [3:0] value;

  logic [15:0] cnt0, cnt1, cnt2;
  logic        ovf0, ovf1, ovf2;
  logic        zr0, zr1, zr2;
  logic        od0, od1, od2;
  state_e      st0, st1, st2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state per instance.
  int m_cnt [3];
  bit m_ovf [3];

  // clock / reset block
  always #5 clk = ~clk;

  fsm_counter_nbit #(.SATURATE(1'b0), .ROTATE(1'b0)) dut0 (
    .clock(clk), .reset(reset), .enable(enable), .check(check), .mode(mode),
    .direction(direction), .value(value), .count(cnt0), .overflow(ovf0),
    .zero(zr0), .op_done(od0), .dbg_state_o(st0));

  fsm_counter_nbit #(.SATURATE(1'b1), .ROTATE(1'b0)) dut1 (
    .clock(clk), .reset(reset), .enable(enable), .check(check), .mode(mode),
    .direction(direction), .value(value), .count(cnt1), .overflow(ovf1),
    .zero(zr1), .op_done(od1), .dbg_state_o(st1));

  fsm_counter_nbit #(.SATURATE(1'b0), .ROTATE(1'b1)) dut2 (
    .clock(clk), .reset(reset), .enable(enable), .check(check), .mode(mode),
    .direction(direction), .value(value), .count(cnt2), .overflow(ovf2),
    .zero(zr2), .op_done(od2), .dbg_state_o(st2));

  function automatic logic [15:0] get_cnt(int i);
    case (i)
      0: return cnt0;
      1: return cnt1;
      default: return cnt2;
    endcase
  endfunction

  function automatic logic get_ovf(int i);
    case (i)
      0: return ovf0;
      1: return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic logic get_zero(int i);
    case (i)
      0: return zr0;
      1: return zr1;
      default: return zr2;
    endcase
  endfunction

  function automatic logic get_done(int i);
    case (i)
      0: return od0;
      1: return od1;
      default: return od2;
    endcase
  endfunction

  function automatic state_e get_state(int i);
    case (i)
      0: return st0;
      1: return st1;
      default: return st2;
    endcase
  endfunction

  // Model: the counter as an integer in [0, 65535].
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input bit chk, input bit md, input bit dr, input int v);
    for (int i = 0; i < 3; i++) begin
      bit sat;
      bit rot;
      int r;
      sat = (i == 1);
      rot = (i == 2);
      if (chk) begin
        m_cnt[i] = 'h1382;
        m_ovf[i] = 1'b0;
      end else if (md && !dr) begin
        r = m_cnt[i] + v;
        if (r > 65535) begin
          m_ovf[i] = 1'b1;
          r = sat ? 65535 : r - 65536;
        end
        m_cnt[i] = r;
      end else if (md && dr) begin
        r = m_cnt[i] - v;
        if (r < 0) begin
          m_ovf[i] = 1'b1;
          r = sat ? 0 : r + 65536;
        end
        m_cnt[i] = r;
      end else if (!dr) begin
        r = (m_cnt[i] * 2) % 65536;
        if (rot) r = r + m_cnt[i] / 32768;
        m_cnt[i] = r;
      end else begin
        r = m_cnt[i] / 2;
        if (rot) r = r + (m_cnt[i] % 2) * 32768;
        m_cnt[i] = r;
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    enable    = 1'b0;
    check     = 1'b0;
    mode      = 1'b0;
    direction = 1'b0;
    value     = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One press: enable held for hold_extra cycles beyond the op, then released.
  // Checks single op_done at the 2nd edge and the model result afterwards.
  task automatic press(input bit chk, input bit md, input bit dr, input int v,
                       input int hold_extra);
    int done_cnt [3];
    int first_at [3];
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      first_at[i] = -1;
    end
    @(negedge clk);
    check     = chk;
    mode      = md;
    direction = dr;
    value     = 4'(v);
    enable    = 1'b1;
    for (int cyc = 1; cyc <= hold_extra + 3; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (get_done(i) === 1'b1) begin
          done_cnt[i]++;
          if (first_at[i] < 0) first_at[i] = cyc;
        end
      end
      if (cyc == 2) begin
        check     = $urandom_range(0, 1);
        mode      = $urandom_range(0, 1);
        direction = $urandom_range(0, 1);
        value     = 4'($urandom_range(0, 15));
      end
      if (cyc == hold_extra + 2) enable = 1'b0;
    end
    model_apply(chk, md, dr, v);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (done_cnt[i] !== 1 || first_at[i] !== 2)
        $display("FAIL op_done[%0d]: pulses=%0d first_edge=%0d, required 1 pulse at edge 2",
                 i, done_cnt[i], first_at[i]);
      else n_pass++;
      n_checks++;
      if (get_cnt(i) !== 16'(m_cnt[i]))
        $display("FAIL count[%0d]: got %h, required %h", i, get_cnt(i), 16'(m_cnt[i]));
      else n_pass++;
      n_checks++;
      if (get_ovf(i) !== m_ovf[i])
        $display("FAIL overflow[%0d]: got %b, required %b", i, get_ovf(i), m_ovf[i]);
      else n_pass++;
      n_checks++;
      if (get_zero(i) !== (m_cnt[i] == 0))
        $display("FAIL zero[%0d]: got %b, required %b", i, get_zero(i), (m_cnt[i] == 0));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (get_cnt(i) !== 16'h0 || get_ovf(i) !== 1'b0 || get_zero(i) !== 1'b1 ||
          get_done(i) !== 1'b0 || get_state(i) !== HOLD)
        $display("FAIL reset[%0d]: cnt=%h ovf=%b zero=%b done=%b st=%0d, required 0/0/1/0/HOLD",
                 i, get_cnt(i), get_ovf(i), get_zero(i), get_done(i), get_state(i));
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_seed();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 0, 1);
    n_checks++;
    if (cnt0 !== 16'h1382 || zr0 !== 1'b0)
      $display("FAIL seed: cnt=%h zero=%b, required 1382/0", cnt0, zr0);
    else n_pass++;
  endtask

  task automatic test_add_five();
    do_reset();
    for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b0, 6, $urandom_range(0, 2));
    n_checks++;
    if (cnt0 !== 16'h001E || ovf0 !== 1'b0)
      $display("FAIL add_five: cnt=%h ovf=%b, required 001e/0", cnt0, ovf0);
    else n_pass++;
  endtask

  task automatic test_sub_shift();
    do_reset();
    for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b1, 3, 1);
    n_checks++;
    if (cnt0 !== 16'hFFF1 || ovf0 !== 1'b1)
      $display("FAIL sub_wrap: cnt=%h ovf=%b, required fff1/1", cnt0, ovf0);
    else n_pass++;
    n_checks++;
    if (cnt1 !== 16'h0000 || ovf1 !== 1'b1 || zr1 !== 1'b1)
      $display("FAIL sub_sat: cnt=%h ovf=%b zero=%b, required 0000/1/1", cnt1, ovf1, zr1);
    else n_pass++;
    for (int k = 0; k < 5; k++) press(1'b0, 1'b0, 1'b0, 0, 1);
    n_checks++;
    if (cnt0 !== 16'hFE20 || cnt2 !== 16'hFE3F)
      $display("FAIL shl5: shift=%h rot=%h, required fe20/fe3f", cnt0, cnt2);
    else n_pass++;
    for (int k = 0; k < 5; k++) press(1'b0, 1'b0, 1'b1, 0, 1);
    n_checks++;
    if (cnt0 !== 16'h07F1 || ovf0 !== 1'b1)
      $display("FAIL shr5: cnt=%h ovf=%b, required 07f1/1", cnt0, ovf0);
    else n_pass++;
  endtask

  task automatic test_long_hold();
    do_reset();
    press(1'b0, 1'b1, 1'b0, 1, 18);
    for (int k = 0; k < 4; k++) press(1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (cnt0 !== 16'h0010)
      $display("FAIL long_hold: cnt=%h, required 0010", cnt0);
    else n_pass++;
  endtask

  task automatic test_reset_in_exec();
    int spurious;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    mode      = 1'b1;
    direction = 1'b0;
    value     = 4'd5;
    enable    = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (get_cnt(i) !== 16'h0 || get_done(i) !== 1'b0 || get_ovf(i) !== 1'b0)
        $display("FAIL reset_exec[%0d]: cnt=%h done=%b ovf=%b, required 0000/0/0",
                 i, get_cnt(i), get_done(i), get_ovf(i));
      else n_pass++;
    end
    reset    = 1'b0;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (get_done(i) !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious !== 0 || cnt0 !== 16'h0)
      $display("FAIL held_after_reset: done_pulses=%0d cnt=%h, required 0/0000", spurious, cnt0);
    else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    press(1'b0, 1'b1, 1'b0, 1, 1);
  endtask

  task automatic test_random();
    do_reset();
    press(1'b0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      press(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 3));
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    check     = 1'b0;
    mode      = 1'b0;
    direction = 1'b0;
    value     = 4'd0;
    model_reset();
    test_reset();
    test_seed();
    test_add_five();
    test_sub_shift();
    test_long_hold();
    test_reset_in_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
